// File: rtl/tdm_pkg.sv
// Shared types and sizes for the 4-channel TDM receive path.
package tdm_pkg;
    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;
    localparam int MISS_W = 3;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// Purpose: wrapping slot index with increment, realign-to-1 and clear.
// Latency: new index visible one clock after the request.
// Backpressure: none; requests are gated upstream by the enable.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              load_one,
    input  logic              clear,
    output logic [SLOT_W-1:0] slot
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot <= '0;
        end else if (clear) begin
            slot <= '0;
        end else if (load_one) begin
            slot <= SLOT_W'(1);
        end else if (inc) begin
            slot <= slot + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_4ch.sv
// Purpose: lock to frame sync and demultiplex a 4-slot serial stream into a 4-bit frame.
// Latency: slot-3 sample to data/frame_valid is one clock.
// Backpressure: enable_ high freezes all state; strobes drop to 0 while frozen.
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_,
    input  logic              sync,
    input  logic              signal_i,
    output logic [NUM_CH-1:0] data,
    output logic              frame_valid,
    output logic [SLOT_W-1:0] channel,
    output logic              locked,
    output logic              sync_error
);

    localparam logic [MISS_W:0] MISS_LIM_V = (MISS_W+1)'(MISS_LIMIT);

    state_t              state, state_nxt;
    logic [NUM_CH-2:0]   shadow, shadow_nxt;
    logic [NUM_CH-1:0]   data_nxt;
    logic [MISS_W-1:0]   miss_cnt, miss_nxt;
    logic                fv_nxt, se_nxt;
    logic                slot_inc, slot_load, slot_clr;
    logic [MISS_W:0]     miss_plus;

    assign miss_plus = {1'b0, miss_cnt} + 1'b1;

    tdm_slot_counter u_slot (
        .clk      (clk),
        .reset    (reset),
        .inc      (slot_inc),
        .load_one (slot_load),
        .clear    (slot_clr),
        .slot     (channel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            shadow      <= '0;
            data        <= '0;
            miss_cnt    <= '0;
            frame_valid <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            data        <= data_nxt;
            miss_cnt    <= miss_nxt;
            frame_valid <= fv_nxt;
            sync_error  <= se_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        data_nxt   = data;
        miss_nxt   = miss_cnt;
        fv_nxt     = 1'b0;
        se_nxt     = 1'b0;
        slot_inc   = 1'b0;
        slot_load  = 1'b0;
        slot_clr   = 1'b0;

        if (!enable_) begin
            if (state == HUNT) begin
                if (sync) begin
                    shadow_nxt[0] = signal_i;
                    slot_load     = 1'b1;
                    miss_nxt      = '0;
                    state_nxt     = LOCKED;
                end
            end else if (sync && channel != '0) begin
                // Misaligned sync: drop the partial frame and restart at slot 0.
                se_nxt        = 1'b1;
                shadow_nxt[0] = signal_i;
                slot_load     = 1'b1;
                miss_nxt      = '0;
            end else begin
                case (channel)
                    2'd0: begin
                        if (sync) begin
                            shadow_nxt[0] = signal_i;
                            miss_nxt      = '0;
                            slot_inc      = 1'b1;
                        end else if (miss_plus < MISS_LIM_V) begin
                            // Flywheel through a missing sync.
                            shadow_nxt[0] = signal_i;
                            miss_nxt      = miss_cnt + 1'b1;
                            slot_inc      = 1'b1;
                        end else begin
                            state_nxt = HUNT;
                            slot_clr  = 1'b1;
                            miss_nxt  = '0;
                        end
                    end
                    2'd3: begin
                        data_nxt = {signal_i, shadow};
                        fv_nxt   = 1'b1;
                        slot_inc = 1'b1;
                    end
                    default: begin
                        shadow_nxt[channel] = signal_i;
                        slot_inc            = 1'b1;
                    end
                endcase
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed vector table plus hand-written sequences for reset and back-to-back frames.
module tb_tdm_demux_4ch;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable_;
    logic       sync;
    logic       signal_i;
    logic [3:0] data;
    logic       frame_valid;
    logic [1:0] channel;
    logic       locked;
    logic       sync_error;

    int n_checks = 0;
    int n_fail   = 0;

    tdm_demux_4ch #(.MISS_LIMIT(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_     (enable_),
        .sync        (sync),
        .signal_i    (signal_i),
        .data        (data),
        .frame_valid (frame_valid),
        .channel     (channel),
        .locked      (locked),
        .sync_error  (sync_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en_n;
        logic       sy;
        logic       sig;
        logic [3:0] exp_data;
        logic       exp_fv;
        logic [1:0] exp_ch;
        logic       exp_lk;
        logic       exp_se;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en_n, input logic sy, input logic sig,
                       input logic [3:0] d, input logic fv, input logic [1:0] ch,
                       input logic lk, input logic se);
        vec_t v;
        v.en_n = en_n; v.sy = sy; v.sig = sig;
        v.exp_data = d; v.exp_fv = fv; v.exp_ch = ch; v.exp_lk = lk; v.exp_se = se;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_step(input logic en_n, input logic sy, input logic sig);
        enable_  = en_n;
        sync     = sy;
        signal_i = sig;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fv_count;
        int last_fv;
        logic [3:0] pat;

        // en_n sync sig | data fv ch locked sync_error (after the edge)
        add(0,0,0, 4'h0,0,0,0,0);   // HUNT, no sync
        add(0,1,1, 4'h0,0,1,1,0);   // lock, frame 1,0,1,1
        add(0,0,0, 4'h0,0,2,1,0);
        add(0,0,1, 4'h0,0,3,1,0);
        add(0,0,1, 4'hD,1,0,1,0);
        add(0,1,0, 4'hD,0,1,1,0);   // frame 0,1,1,0
        add(0,0,1, 4'hD,0,2,1,0);
        add(0,0,1, 4'hD,0,3,1,0);
        add(0,0,0, 4'h6,1,0,1,0);
        add(0,1,1, 4'h6,0,1,1,0);   // frame 1,1,0,1 with a freeze at channel 2
        add(0,0,1, 4'h6,0,2,1,0);
        add(1,1,0, 4'h6,0,2,1,0);
        add(1,0,1, 4'h6,0,2,1,0);
        add(1,1,1, 4'h6,0,2,1,0);
        add(0,0,0, 4'h6,0,3,1,0);
        add(0,0,1, 4'hB,1,0,1,0);
        add(1,0,0, 4'hB,0,0,1,0);   // freeze right after completion kills the strobe
        add(0,1,1, 4'hB,0,1,1,0);   // partial frame, then sync at channel 2
        add(0,0,1, 4'hB,0,2,1,0);
        add(0,1,0, 4'hB,0,1,1,1);
        add(0,0,0, 4'hB,0,2,1,0);
        add(0,0,1, 4'hB,0,3,1,0);
        add(0,0,0, 4'h4,1,0,1,0);
        add(0,1,1, 4'h4,0,1,1,0);   // sync at channel 3 beats frame completion
        add(0,0,1, 4'h4,0,2,1,0);
        add(0,0,1, 4'h4,0,3,1,0);
        add(0,1,0, 4'h4,0,1,1,1);
        add(0,0,1, 4'h4,0,2,1,0);
        add(0,0,1, 4'h4,0,3,1,0);
        add(0,0,1, 4'hE,1,0,1,0);
        add(0,0,1, 4'hE,0,1,1,0);   // first missing sync: flywheel
        add(0,0,0, 4'hE,0,2,1,0);
        add(0,0,0, 4'hE,0,3,1,0);
        add(0,0,0, 4'h1,1,0,1,0);
        add(0,0,1, 4'h1,0,0,0,0);   // second missing sync: lock lost
        add(0,0,1, 4'h1,0,0,0,0);
        add(0,0,0, 4'h1,0,0,0,0);
        add(0,1,0, 4'h1,0,1,1,0);   // relock, frame 0,1,0,1
        add(0,0,1, 4'h1,0,2,1,0);
        add(0,0,0, 4'h1,0,3,1,0);
        add(0,0,1, 4'hA,1,0,1,0);
        add(0,1,1, 4'hA,0,1,1,0);
        add(0,0,0, 4'hA,0,2,1,0);

        enable_ = 1'b0; sync = 1'b0; signal_i = 1'b0;
        reset = 1'b1;
        #12;
        chk("rst_data",   data,              4'h0);
        chk("rst_fv",     {3'b0,frame_valid},4'h0);
        chk("rst_ch",     {2'b0,channel},    4'h0);
        chk("rst_locked", {3'b0,locked},     4'h0);
        chk("rst_serr",   {3'b0,sync_error}, 4'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive_step(vecs[i].en_n, vecs[i].sy, vecs[i].sig);
            chk($sformatf("v%0d_data", i), data,                 vecs[i].exp_data);
            chk($sformatf("v%0d_fv", i),   {3'b0,frame_valid},   {3'b0,vecs[i].exp_fv});
            chk($sformatf("v%0d_ch", i),   {2'b0,channel},       {2'b0,vecs[i].exp_ch});
            chk($sformatf("v%0d_lk", i),   {3'b0,locked},        {3'b0,vecs[i].exp_lk});
            chk($sformatf("v%0d_se", i),   {3'b0,sync_error},    {3'b0,vecs[i].exp_se});
        end

        // Asynchronous reset mid-frame (locked, channel 2).
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_data", data,               4'h0);
        chk("mid_rst_lk",   {3'b0,locked},      4'h0);
        chk("mid_rst_ch",   {2'b0,channel},     4'h0);
        chk("mid_rst_fv",   {3'b0,frame_valid}, 4'h0);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Ten back-to-back aligned frames.
        fv_count = 0;
        last_fv  = -1;
        for (int k = 0; k < 40; k++) begin
            int slot;
            int f;
            slot = k % 4;
            f    = k / 4;
            pat  = 4'((f * 5 + 3) % 16);
            chk($sformatf("b2b%0d_ch", k), {2'b0,channel}, 4'(slot));
            drive_step(1'b0, slot == 0, pat[slot]);
            chk($sformatf("b2b%0d_fv", k), {3'b0,frame_valid}, {3'b0, slot == 3});
            chk($sformatf("b2b%0d_se", k), {3'b0,sync_error},  4'h0);
            if (frame_valid) begin
                fv_count++;
                chk($sformatf("b2b%0d_data", k), data, pat);
                if (last_fv >= 0)
                    chk($sformatf("b2b%0d_gap", k), 4'(k - last_fv), 4'd4);
                last_fv = k;
            end
        end
        chk("b2b_count", 4'(fv_count), 4'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
